mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port synchronous memory between the CPU and a second master (debug/loader port driven from board switches).
- Sits between the requesters and the memory instance, on the divided system clock.
- Round-robin with bounded burst ownership.
- Returns read data with a per-requester valid pulse.
- Counts contention cycles for on-board display.

Parameters:
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory data width
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting (range 1..15)

Ports:
- clk  input  1  system clock (divided clock domain)
- rst_n  input  1  reset, synchronous, active-low
- req0  input  1  requester 0 (CPU) access request, held until granted
- we0  input  1  requester 0 write enable (1 = write, 0 = read)
- addr0  input  ADDR_WIDTH  requester 0 address
- wdata0  input  DATA_WIDTH  requester 0 write data
- gnt0  output  1  requester 0 access accepted this cycle
- rvalid0  output  1  requester 0 read data valid
- rdata0  output  DATA_WIDTH  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above, for requester 1 (debug port)
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_data  output  DATA_WIDTH  memory write data
- mem_in  input  DATA_WIDTH  memory read data, valid one cycle after the address
- conflict_cnt  output  8  saturating count of cycles in which a requesting master was denied

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- State register: owner ∈ {IDLE, OWN0, OWN1}, the owner of the previous cycle.
- Other registers: last (last granted index), burst_cnt (4 bits), rd_pend0/rd_pend1, conflict_cnt.
- Reset values, applied at a clk edge with rst_n=0:
  - owner=IDLE, last=1 (so req0 wins first tie), burst_cnt=0.
  - rvalid0=rvalid1=0, rdata0=rdata1=0, conflict_cnt=0.
- While rst_n=0: gnt0=gnt1=0 and mem_we=0 combinationally; no access is accepted.
- Winner selection (combinational, same cycle):
  - Neither req: no grant. mem_we=0, mem_addr=0, mem_data=0. Next owner=IDLE, burst_cnt=0.
  - One req: that requester wins, regardless of burst_cnt.
  - Both req, owner=OWNx and burst_cnt<MAX_BURST: x wins.
  - Both req, otherwise (burst exhausted, or owner=IDLE): the requester ≠ last wins.
- Grant cycle:
  - gnt_w=1 and the other gnt=0. gnt0 and gnt1 are never both 1.
  - mem_we, mem_addr, mem_data are muxed from the winner's we/addr/wdata in the same cycle.
  - The access is complete at that clk edge.
- State update on a grant:
  - If winner == previous owner: burst_cnt increments, saturating at 15. Otherwise burst_cnt=1.
  - owner=OWNw, last=w.
- Read return:
  - If the granted access was a read, rvalid_w=1 exactly one cycle later with rdata_w=mem_in.
  - Writes never produce rvalid.
  - rvalid pulses last one cycle.
  - rdata holds its last value when rvalid=0.
- Pipelining: back-to-back reads from the same requester give one grant per cycle and one rvalid per cycle, with 1-cycle latency.
- Contention: conflict_cnt increments in any cycle where both req=1 (exactly one requester denied). Saturates at 255.
- Reset mid-operation: a read granted in the cycle before reset asserts does not produce rvalid. Pending state is cleared.
- Requesters must hold req/we/addr/wdata stable until gnt. Changing them without a grant is legal; the arbiter evaluates current values each cycle.
- MAX_BURST=1 degenerates to strict alternation under contention.

Test Plan:
- Reset, then req0 read of addr 5 (mem holds 0x1234), req1=0 → gnt0=1 in cycle 0; rvalid0=1 with rdata0=0x1234 in cycle 1; gnt1, rvalid1, conflict_cnt stay 0.
- req0 and req1 held high continuously, MAX_BURST=4, from reset → grant sequence 0,0,0,0,1,1,1,1,0,…; never both gnt; conflict_cnt increments every cycle.
- req1 write 0xBEEF to addr 10, then req0 read addr 10 the next cycle → mem_we=1 only in the write cycle; rvalid0 next cycle with 0xBEEF; rvalid1 never asserts.
- Only req1 high for 20 cycles → gnt1 every cycle despite burst_cnt saturating; conflict_cnt=0.
- req0 read granted, rst_n=0 on the next edge → rvalid0 stays 0; after release, owner=IDLE and a simultaneous req0/req1 grants requester 0 first.
- Both requesting for 300 cycles → conflict_cnt saturates at 255 and holds.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-master memory arbiter.
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them stable
// until gntN is seen high in the same cycle; the access completes at that clk edge.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_in;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_in,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_in,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded burst ownership sharing one synchronous
// single-port memory between the CPU (requester 0) and a debug/loader port.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus,
  output logic [7:0]  conflict_cnt,
  output logic [1:0]  dbg_owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  owner_e                owner_q, owner_d;
  logic                  last_q, last_d;
  logic [3:0]            burst_q, burst_d;
  logic                  rd_pend0_q, rd_pend0_d;
  logic                  rd_pend1_q, rd_pend1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  win0, win1;
  logic [3:0]            burst_inc;

  assign burst_inc = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;

  always_comb begin
    win0          = 1'b0;
    win1          = 1'b0;
    owner_d       = IDLE;
    burst_d       = 4'd0;
    last_d        = last_q;
    rd_pend0_d    = 1'b0;
    rd_pend1_d    = 1'b0;
    cnt_d         = cnt_q;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    if (rst_n) begin
      if (bus.req0 && bus.req1) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Current owner keeps the memory until its burst budget runs out.
        if (owner_q == OWN0 && burst_q < MAX_B)      win0 = 1'b1;
        else if (owner_q == OWN1 && burst_q < MAX_B) win1 = 1'b1;
        else if (last_q)                             win0 = 1'b1;
        else                                         win1 = 1'b1;
      end else if (bus.req0) begin
        win0 = 1'b1;
      end else if (bus.req1) begin
        win1 = 1'b1;
      end

      if (win0) begin
        bus.mem_we   = bus.we0;
        bus.mem_addr = bus.addr0;
        bus.mem_data = bus.wdata0;
        owner_d      = OWN0;
        last_d       = 1'b0;
        burst_d      = (owner_q == OWN0) ? burst_inc : 4'd1;
        rd_pend0_d   = ~bus.we0;
      end else if (win1) begin
        bus.mem_we   = bus.we1;
        bus.mem_addr = bus.addr1;
        bus.mem_data = bus.wdata1;
        owner_d      = OWN1;
        last_d       = 1'b1;
        burst_d      = (owner_q == OWN1) ? burst_inc : 4'd1;
        rd_pend1_d   = ~bus.we1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= IDLE;
      last_q     <= 1'b1;
      burst_q    <= 4'd0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      cnt_q      <= 8'd0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
      cnt_q      <= cnt_d;
      if (rd_pend0_q) rdata0_q <= bus.mem_in;
      if (rd_pend1_q) rdata1_q <= bus.mem_in;
    end
  end

  // Memory data arrives the cycle after the grant, so read return is a bypass of mem_in.
  assign bus.gnt0    = win0;
  assign bus.gnt1    = win1;
  assign bus.rvalid0 = rd_pend0_q;
  assign bus.rvalid1 = rd_pend1_q;
  assign bus.rdata0  = rd_pend0_q ? bus.mem_in : rdata0_q;
  assign bus.rdata1  = rd_pend1_q ? bus.mem_in : rdata1_q;
  assign conflict_cnt = cnt_q;
  assign dbg_owner_o  = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenario tasks plus a read-return
// scoreboard fed by a shadow copy of the memory contents.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  logic [7:0] conflict_cnt;
  logic [1:0] dbg_owner;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] mem    [64];
  logic [DW-1:0] shadow [64];
  logic [DW-1:0] exp0_q [$];
  logic [DW-1:0] exp1_q [$];

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt),
    .dbg_owner_o  (dbg_owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous memory model, read-first
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_in <= mem[bus.mem_addr];
  end

  // scoreboard
  always @(posedge clk) begin
    if (!rst_n) begin
      exp0_q.delete();
      exp1_q.delete();
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    tests_run++;
    if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
      tests_failed++;
      $display("FAIL both_gnt: gnt0=%b gnt1=%b required not both 1", bus.gnt0, bus.gnt1);
    end
    if (bus.rvalid0 === 1'b1) begin
      tests_run++;
      if (exp0_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rvalid0_unexpected: rvalid0=1 with no read outstanding");
      end else begin
        e = exp0_q.pop_front();
        if (bus.rdata0 !== e) begin
          tests_failed++;
          $display("FAIL rdata0: got %h expected %h", bus.rdata0, e);
        end
      end
    end
    if (bus.rvalid1 === 1'b1) begin
      tests_run++;
      if (exp1_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rvalid1_unexpected: rvalid1=1 with no read outstanding");
      end else begin
        e = exp1_q.pop_front();
        if (bus.rdata1 !== e) begin
          tests_failed++;
          $display("FAIL rdata1: got %h expected %h", bus.rdata1, e);
        end
      end
    end
    if (rst_n && bus.gnt0 === 1'b1) begin
      if (bus.we0) shadow[bus.addr0] = bus.wdata0;
      else exp0_q.push_back(shadow[bus.addr0]);
    end
    if (rst_n && bus.gnt1 === 1'b1) begin
      if (bus.we1) shadow[bus.addr1] = bus.wdata1;
      else exp1_q.push_back(shadow[bus.addr1]);
    end
  end

  // driver tasks
  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd1; bus.wdata0 = 16'h1111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd2; bus.wdata1 = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gating: gnt0=%b gnt1=%b mem_we=%b required 0 0 0", bus.gnt0, bus.gnt1, bus.mem_we);
    end
    tests_run++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== 16'h0 || bus.rdata1 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_rd: rvalid=%b%b rdata0=%h rdata1=%h required 0", bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1);
    end
    tests_run++;
    if (conflict_cnt !== 8'd0 || dbg_owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: conflict_cnt=%0d owner=%0d required 0 0", conflict_cnt, dbg_owner);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.mem_addr !== 6'd5 || bus.mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_read_gnt: gnt0=%b gnt1=%b addr=%0d we=%b required 1 0 5 0", bus.gnt0, bus.gnt1, bus.mem_addr, bus.mem_we);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL single_read_data: rvalid0=%b rdata0=%h required 1 1234", bus.rvalid0, bus.rdata0);
    end
    tests_run++;
    if (bus.rvalid1 !== 1'b0 || bus.gnt1 !== 1'b0 || conflict_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL single_read_side: rvalid1=%b gnt1=%b conflict_cnt=%0d required 0 0 0", bus.rvalid1, bus.gnt1, conflict_cnt);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL rdata_hold: rvalid0=%b rdata0=%h required 0 1234", bus.rvalid0, bus.rdata0);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_g0;
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'($urandom_range(0, 63));
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'($urandom_range(0, 63));
    for (int i = 0; i < 16; i++) begin
      exp_g0 = ((i / 4) % 2) == 0;
      @(negedge clk);
      tests_run++;
      if (bus.gnt0 !== exp_g0 || bus.gnt1 !== !exp_g0) begin
        tests_failed++;
        $display("FAIL contention_gnt[%0d]: gnt0=%b gnt1=%b required %b %b", i, bus.gnt0, bus.gnt1, exp_g0, !exp_g0);
      end
      tests_run++;
      if (conflict_cnt !== 8'(i)) begin
        tests_failed++;
        $display("FAIL contention_cnt[%0d]: got %0d required %0d", i, conflict_cnt, i);
      end
      next_cycle();
      bus.addr0 = 6'($urandom_range(0, 63));
      bus.addr1 = 6'($urandom_range(0, 63));
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_then_read();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd10; bus.wdata1 = 16'hBEEF;
    @(negedge clk);
    tests_run++;
    if (bus.gnt1 !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10 || bus.mem_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL wr_cycle: gnt1=%b we=%b addr=%0d data=%h required 1 1 10 beef", bus.gnt1, bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    next_cycle();
    idle_inputs();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd10;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_cycle: gnt0=%b mem_we=%b rvalid1=%b required 1 0 0", bus.gnt0, bus.mem_we, bus.rvalid1);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'hBEEF || bus.rvalid1 !== 1'b0 || bus.mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_rd_data: rvalid0=%b rdata0=%h rvalid1=%b mem_we=%b required 1 beef 0 0", bus.rvalid0, bus.rdata0, bus.rvalid1, bus.mem_we);
    end
    next_cycle();
  endtask

  task automatic test_single_requester();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus.req1 = (i < 20); bus.we1 = 1'b0; bus.addr1 = 6'($urandom_range(0, 63));
      @(negedge clk);
      tests_run++;
      if (bus.gnt1 !== (i < 20) || bus.gnt0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL solo_gnt[%0d]: gnt1=%b gnt0=%b required %b 0", i, bus.gnt1, bus.gnt0, (i < 20));
      end
      tests_run++;
      if (bus.rvalid1 !== (i > 0)) begin
        tests_failed++;
        $display("FAIL solo_rvalid[%0d]: rvalid1=%b required %b", i, bus.rvalid1, (i > 0));
      end
      next_cycle();
    end
    tests_run++;
    if (conflict_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL solo_cnt: conflict_cnt=%0d required 0", conflict_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_gnt: gnt0=%b required 1", bus.gnt0);
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (bus.rvalid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rvalid: rvalid0=%b required 0", bus.rvalid0);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dbg_owner !== 2'd0 || bus.rvalid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_owner: owner=%0d rvalid0=%b required 0 0", dbg_owner, bus.rvalid0);
    end
    next_cycle();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd7;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd8;
    @(negedge clk);
    tests_run++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_first: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt;
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.addr0 = 6'($urandom_range(0, 63));
      bus.addr1 = 6'($urandom_range(0, 63));
      exp_cnt = (i < 255) ? 8'(i) : 8'd255;
      @(negedge clk);
      tests_run++;
      if (conflict_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL sat_cnt[%0d]: got %0d required %0d", i, conflict_cnt, exp_cnt);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (conflict_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d required 255", conflict_cnt);
    end
    next_cycle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 16'(i * 257) ^ 16'h5A00;
      shadow[i] = 16'(i * 257) ^ 16'h5A00;
    end
    mem[5]    = 16'h1234;
    shadow[5] = 16'h1234;
    idle_inputs();
    rst_n = 1'b0;
    #1;

    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_single_requester();
    test_reset_mid();
    test_saturation();

    repeat (2) next_cycle();
    tests_run++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: outstanding reads q0=%0d q1=%0d required 0 0", exp0_q.size(), exp1_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
